// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Moore main state machine of the multicycle ARM control unit
//
// Sequences fetch/decode/memory/execute/writeback cycles from Op/Funct and drives
// the datapath selects plus the unconditional strobes NextPC/RegW/MemW/Branch,
// which condlogic later qualifies with CondEx. Also keeps a retired-instruction
// counter and a sticky illegal-opcode flag for debug.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   Op[1:0], Funct[5:0] instruction fields (sampled only in DECODE / MEMADR)
//   IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp
//                       datapath controls
//   NextPC, RegW, MemW, Branch
//                       unconditional write strobes
//   State[3:0]          current state encoding
//   InstrCount[CNT_W-1:0] instructions retired since reset (wraps)
//   Illegal             sticky, set on entering UNKNOWN

module main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    // Control word for a state; UNKNOWN and the unreachable codes give all zeros,
    // so no write strobe can ever be raised from them.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_MEMADR: begin
                c.alusrca   = 2'b00;
                c.alusrcb   = 2'b01;
            end
            S_MEMRD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = 2'b00;
            end
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            S_MEMWR: begin
                c.adrsrc    = 1'b1;
                c.memw      = 1'b1;
            end
            S_EXECR: begin
                c.alusrca   = 2'b00;
                c.alusrcb   = 2'b00;
                c.aluop     = 1'b1;
            end
            S_EXECI: begin
                c.alusrca   = 2'b00;
                c.alusrcb   = 2'b01;
                c.aluop     = 1'b1;
            end
            S_ALUWB: begin
                c.resultsrc = 2'b00;
                c.regw      = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca   = 2'b10;
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the next-state decode, so they always equal
    // decode_state(state_q) while avoiding combinational output paths.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ctrl_q     <= decode_state(S_FETCH);
            InstrCount <= '0;
            Illegal    <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_state(state_d);
            if (state_q == S_MEMWB || state_q == S_MEMWR ||
                state_q == S_ALUWB || state_q == S_BRANCH) begin
                InstrCount <= InstrCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state_d == S_UNKNOWN) begin
                Illegal <= 1'b1;
            end
        end
    end

    assign State     = state_q;
    assign IRWrite   = ctrl_q.irwrite;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;
    assign ResultSrc = ctrl_q.resultsrc;
    assign ALUOp     = ctrl_q.aluop;
    assign NextPC    = ctrl_q.nextpc;
    assign RegW      = ctrl_q.regw;
    assign MemW      = ctrl_q.memw;
    assign Branch    = ctrl_q.branch;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm with randomized instruction stream

module tb_main_fsm;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    main_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .State(State), .InstrCount(InstrCount),
        .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               st;
        logic [12:0]      o;
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } rec_t;

    rec_t             sb[$];
    int               tr[$];
    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    bit               mon_en = 1'b0;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ill;

    // Spec table of control outputs per state, packed as
    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
    function automatic logic [12:0] exp_outs(input int s);
        logic ir, adr, aop, npc, rw, mw, br;
        logic [1:0] sa, sbb, rs;
        {ir, adr, aop, npc, rw, mw, br} = '0;
        sa = 2'b00; sbb = 2'b00; rs = 2'b00;
        case (s)
            0:  begin ir = 1; npc = 1; sa = 2'b01; sbb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sbb = 2'b10; rs = 2'b10; end
            2:  begin sbb = 2'b01; end
            3:  begin adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin aop = 1; end
            7:  begin sbb = 2'b01; aop = 1; end
            8:  begin rw = 1; end
            9:  begin sa = 2'b10; sbb = 2'b01; rs = 2'b10; br = 1; end
            default: ;
        endcase
        return {ir, adr, sa, sbb, rs, aop, npc, rw, mw, br};
    endfunction

    // Reference state path of one instruction, from FETCH inclusive.
    task automatic build_trace(input logic [1:0] op, input logic [5:0] f);
        tr.delete();
        tr.push_back(0);
        tr.push_back(1);
        case (op)
            2'b00: begin tr.push_back(f[5] ? 7 : 6); tr.push_back(8); end
            2'b01: begin
                tr.push_back(2);
                if (f[0]) begin tr.push_back(3); tr.push_back(4); end
                else      tr.push_back(5);
            end
            2'b10: tr.push_back(9);
            default: tr.push_back(10);
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: the DUT presents a new Moore output every cycle.
    always @(negedge clk) begin
        rec_t r;
        cyc++;
        if (mon_en) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                check("state", {28'd0, State}, r.st);
                check("outputs", {19'd0, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                                  ALUOp, NextPC, RegW, MemW, Branch}, {19'd0, r.o});
                check("instr_count", {28'd0, InstrCount}, {28'd0, r.cnt});
                check("illegal", {31'd0, Illegal}, {31'd0, r.ill});
            end
        end
    end

    // Runs one instruction starting in its FETCH cycle (#2 after a rising edge).
    // abort_at >= 0 asserts reset during that cycle of the trace.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input int abort_at);
        logic [31:0] rnd;
        rec_t r;
        build_trace(op, f);
        for (int k = 0; k < tr.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #2;
            end
            if (tr[k] == 1 || tr[k] == 2) begin
                Op = op; Funct = f;
            end else begin
                rnd = $urandom;
                Op = rnd[1:0]; Funct = rnd[7:2];
            end
            if (tr[k] == 10) m_ill = 1'b1;
            r.st = tr[k]; r.o = exp_outs(tr[k]); r.cnt = m_cnt; r.ill = m_ill;
            sb.push_back(r);
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b0;
                m_cnt = '0;
                m_ill = 1'b0;
                return;
            end
            if (tr[k] == 4 || tr[k] == 5 || tr[k] == 8 || tr[k] == 9) m_cnt = m_cnt + 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] rnd;
        reset = 1'b1; Op = 2'b00; Funct = 6'd0;
        m_cnt = '0; m_ill = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("reset_state", {28'd0, State}, 32'd0);
        check("reset_irwrite", {31'd0, IRWrite}, 32'd1);
        check("reset_nextpc", {31'd0, NextPC}, 32'd1);
        check("reset_count", {28'd0, InstrCount}, 32'd0);
        check("reset_illegal", {31'd0, Illegal}, 32'd0);
        mon_en = 1'b1;

        run_instr(2'b00, 6'b000000, -1);
        run_instr(2'b00, 6'b100001, -1);
        run_instr(2'b01, 6'b011001, -1);
        run_instr(2'b01, 6'b011000, -1);
        run_instr(2'b10, 6'b000000, -1);
        run_instr(2'b11, 6'b000000, -1);

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            run_instr(rnd[1:0], rnd[7:2], -1);
        end

        // Aborts clear the counter and the sticky flag
        run_instr(2'b11, 6'b000000, -1);
        run_instr(2'b01, 6'b000000, 3);
        run_instr(2'b00, 6'b000000, 3);
        // 17 retires: wraps through zero, then abort LDR in MEMRD with count nonzero
        for (int i = 0; i < 17; i++) begin
            rnd = $urandom;
            run_instr(2'b00, rnd[5:0], -1);
        end
        run_instr(2'b01, 6'b011001, 3);
        run_instr(2'b01, 6'b011001, 4);
        run_instr(2'b10, 6'b000000, 2);

        for (int i = 0; i < 20; i++) begin
            rnd = $urandom;
            run_instr(rnd[1:0], rnd[7:2], (rnd[9:8] == 2'b00) ? int'(rnd[11:10]) : -1);
        end

        mon_en = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
